// File: rtl/rhs_mem_pkg.sv
// Shared types and default widths for the RHS memory responder.
package rhs_mem_pkg;

    localparam int LEN_ADDR      = 32;
    localparam int LEN_MEM_DATA  = 512;
    localparam int RHS_BURST_LEN = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STREAM
    } rd_state_t;

endpackage

// File: rtl/rhs_cmd_fifo.sv
// Command FIFO holding base RAM indices of queued read bursts.
module rhs_cmd_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + (AW+1)'(1);
            if (pop && !empty)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/rhs_mem_responder.sv
// Memory-side responder: word-addressed RAM serving writes and in-order
// read bursts of RHS_BURST_LEN beats with receive-side backpressure.
module rhs_mem_responder #(
    parameter int LEN_ADDR       = rhs_mem_pkg::LEN_ADDR,
    parameter int LEN_MEM_DATA   = rhs_mem_pkg::LEN_MEM_DATA,
    parameter int RHS_BURST_LEN  = rhs_mem_pkg::RHS_BURST_LEN,
    parameter int MEM_ADDR_BITS  = 10,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int READ_LATENCY   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LEN_ADDR-1:0]     in_mem_addr,
    input  logic [LEN_MEM_DATA-1:0] in_mem_data,
    input  logic                    in_wrt_enbl_mem,
    input  logic                    in_available_mem,
    input  logic                    in_receive_enbl_mem,
    input  logic                    in_burst_done,
    output logic                    out_ready_to_receive,
    output logic [LEN_MEM_DATA-1:0] out_mem_data,
    output logic                    out_data_ready,
    output logic [15:0]             out_wr_burst_count
);

    import rhs_mem_pkg::*;

    localparam int CW        = $clog2(READ_LATENCY + 1);
    localparam int BW        = (RHS_BURST_LEN > 1) ? $clog2(RHS_BURST_LEN) : 1;
    localparam int RAM_WORDS = 1 << MEM_ADDR_BITS;

    logic [LEN_MEM_DATA-1:0]  ram [RAM_WORDS];
    logic [MEM_ADDR_BITS-1:0] req_idx;
    logic [MEM_ADDR_BITS-1:0] fifo_rdata;
    logic [MEM_ADDR_BITS-1:0] base_q;
    logic [MEM_ADDR_BITS-1:0] cur_addr_q;
    logic [MEM_ADDR_BITS-1:0] ld_addr;
    logic [LEN_MEM_DATA-1:0]  ld_data;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic                     ld_beat;
    logic                     wr_acc;
    logic                     rd_acc;
    logic                     last_beat;
    logic                     unused_addr_hi;
    rd_state_t                state_q;
    rd_state_t                state_d;
    logic [CW-1:0]            cnt_q;
    logic [BW-1:0]            beat_q;

    assign req_idx        = in_mem_addr[MEM_ADDR_BITS-1:0];
    assign unused_addr_hi = ^in_mem_addr[LEN_ADDR-1:MEM_ADDR_BITS];

    assign out_ready_to_receive = rst && !fifo_full;
    assign wr_acc    = in_available_mem && out_ready_to_receive && in_wrt_enbl_mem;
    assign rd_acc    = in_available_mem && out_ready_to_receive && !in_wrt_enbl_mem;
    assign last_beat = (beat_q == BW'(RHS_BURST_LEN - 1));

    rhs_cmd_fifo #(
        .WIDTH (MEM_ADDR_BITS),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_acc),
        .wdata (req_idx),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (wr_acc)
            ram[req_idx] <= in_mem_data;
    end

    // Forward a same-edge write so a loaded beat sees every write accepted at that edge.
    assign ld_data = (wr_acc && (req_idx == ld_addr)) ? in_mem_data : ram[ld_addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!fifo_empty) state_d = WAIT;
            WAIT:    if (cnt_q == CW'(1)) state_d = STREAM;
            STREAM:  if (in_receive_enbl_mem && last_beat)
                         state_d = fifo_empty ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop       = 1'b0;
        ld_beat        = 1'b0;
        ld_addr        = base_q;
        out_data_ready = 1'b0;
        unique case (state_q)
            IDLE:    fifo_pop = !fifo_empty;
            WAIT:    ld_beat  = (cnt_q == CW'(1));
            STREAM: begin
                out_data_ready = 1'b1;
                ld_addr        = cur_addr_q + MEM_ADDR_BITS'(1);
                ld_beat        = in_receive_enbl_mem && !last_beat;
                fifo_pop       = in_receive_enbl_mem && last_beat && !fifo_empty;
            end
            default: ;
        endcase
    end

    // Output beat register: loads on expiry of the latency count or on consumption.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q              <= '0;
            beat_q             <= '0;
            base_q             <= '0;
            cur_addr_q         <= '0;
            out_mem_data       <= '0;
            out_wr_burst_count <= '0;
        end else begin
            if (fifo_pop) begin
                base_q <= fifo_rdata;
                cnt_q  <= CW'(READ_LATENCY);
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (ld_beat) begin
                out_mem_data <= ld_data;
                cur_addr_q   <= ld_addr;
                beat_q       <= (state_q == WAIT) ? '0 : beat_q + BW'(1);
            end
            if (wr_acc && in_burst_done)
                out_wr_burst_count <= out_wr_burst_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_rhs_mem_responder.sv
// Directed self-checking bench for rhs_mem_responder at default parameters.
module tb_rhs_mem_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_mem_addr;
    logic [511:0] in_mem_data;
    logic         in_wrt_enbl_mem;
    logic         in_available_mem;
    logic         in_receive_enbl_mem;
    logic         in_burst_done;
    logic         out_ready_to_receive;
    logic [511:0] out_mem_data;
    logic         out_data_ready;
    logic [15:0]  out_wr_burst_count;

    logic [511:0] model [1024];
    int errors = 0;
    int checks = 0;

    rhs_mem_responder dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_mem_addr          (in_mem_addr),
        .in_mem_data          (in_mem_data),
        .in_wrt_enbl_mem      (in_wrt_enbl_mem),
        .in_available_mem     (in_available_mem),
        .in_receive_enbl_mem  (in_receive_enbl_mem),
        .in_burst_done        (in_burst_done),
        .out_ready_to_receive (out_ready_to_receive),
        .out_mem_data         (out_mem_data),
        .out_data_ready       (out_data_ready),
        .out_wr_burst_count   (out_wr_burst_count)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] pat(input int i);
        logic [511:0] v;
        for (int k = 0; k < 16; k++)
            v[k*32 +: 32] = (32'(i) * 32'h0100_0193) ^ (32'(k) << 8) ^ 32'hDEAD_0000;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic [511:0] d, input logic done);
        in_mem_addr      = 32'(a);
        in_mem_data      = d;
        in_wrt_enbl_mem  = 1'b1;
        in_burst_done    = done;
        in_available_mem = 1'b1;
        step();
        in_available_mem = 1'b0;
        in_burst_done    = 1'b0;
        model[a % 1024]  = d;
    endtask

    task automatic do_read(input int a);
        in_mem_addr      = 32'(a);
        in_wrt_enbl_mem  = 1'b0;
        in_available_mem = 1'b1;
        step();
        in_available_mem = 1'b0;
    endtask

    task automatic wait_dv(input int budget, output int cyc);
        int n = 0;
        while (out_data_ready !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        cyc = (out_data_ready === 1'b1) ? n : -1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_mem_addr = '0; in_mem_data = '0; in_wrt_enbl_mem = 1'b0;
        in_available_mem = 1'b0; in_receive_enbl_mem = 1'b0; in_burst_done = 1'b0;
        repeat (3) step();
        checks++; if (out_ready_to_receive !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", out_ready_to_receive); end
        checks++; if (out_data_ready !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", out_data_ready); end
        checks++; if (out_mem_data !== 512'd0) begin errors++; $display("FAIL reset_data: got %h want 0", out_mem_data); end
        checks++; if (out_wr_burst_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %h want 0", out_wr_burst_count); end
        rst = 1'b1;
        #1;
        checks++; if (out_ready_to_receive !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", out_ready_to_receive); end
        step();
        checks++; if (out_ready_to_receive !== 1'b1) begin errors++; $display("FAIL first_cycle_ready: got %b want 1", out_ready_to_receive); end
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) do_write(i, pat(i), 1'b0);
        for (int i = 1020; i < 1024; i++) do_write(i, pat(i), 1'b0);
    endtask

    task automatic test_basic_read();
        logic exp_v;
        do_write(5, {64{8'hA5}}, 1'b0);
        in_receive_enbl_mem = 1'b1;
        do_read(4);
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_v = (k >= 3 && k <= 6);
            checks++; if (out_data_ready !== exp_v) begin errors++; $display("FAIL basic_dv[%0d]: got %b want %b", k, out_data_ready, exp_v); end
            if (exp_v) begin
                checks++; if (out_mem_data !== model[4 + k - 3]) begin errors++; $display("FAIL basic_beat[%0d]: got %h want %h", k - 3, out_mem_data, model[4 + k - 3]); end
            end
        end
    endtask

    task automatic test_wrap();
        int cyc;
        in_receive_enbl_mem = 1'b1;
        in_wrt_enbl_mem  = 1'b0;
        in_mem_addr      = 32'hABCD_03FE;
        in_available_mem = 1'b1;
        step();
        in_available_mem = 1'b0;
        wait_dv(20, cyc);
        checks++; if (cyc < 0) begin errors++; $display("FAIL wrap_timeout: got no data_ready want data_ready within 20 cycles"); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            checks++; if (out_mem_data !== model[(1022 + i) % 1024] || out_data_ready !== 1'b1) begin errors++; $display("FAIL wrap_beat[%0d]: got %h want %h", i, out_mem_data, model[(1022 + i) % 1024]); end
        end
        step();
        checks++; if (out_data_ready !== 1'b0) begin errors++; $display("FAIL wrap_end_dv: got %b want 0", out_data_ready); end
    endtask

    task automatic test_stall();
        int cyc;
        in_receive_enbl_mem = 1'b1;
        do_read(8);
        wait_dv(20, cyc);
        checks++; if (cyc < 0) begin errors++; $display("FAIL stall_timeout: got no data_ready want data_ready within 20 cycles"); end
        checks++; if (out_mem_data !== model[8]) begin errors++; $display("FAIL stall_beat0: got %h want %h", out_mem_data, model[8]); end
        step();
        in_receive_enbl_mem = 1'b0;
        checks++; if (out_mem_data !== model[9]) begin errors++; $display("FAIL stall_beat1: got %h want %h", out_mem_data, model[9]); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (out_data_ready !== 1'b1 || out_mem_data !== model[9]) begin errors++; $display("FAIL stall_hold[%0d]: got dv=%b %h want dv=1 %h", k, out_data_ready, out_mem_data, model[9]); end
        end
        in_receive_enbl_mem = 1'b1;
        step();
        checks++; if (out_mem_data !== model[10]) begin errors++; $display("FAIL stall_beat2: got %h want %h", out_mem_data, model[10]); end
        step();
        checks++; if (out_mem_data !== model[11]) begin errors++; $display("FAIL stall_beat3: got %h want %h", out_mem_data, model[11]); end
        step();
        checks++; if (out_data_ready !== 1'b0) begin errors++; $display("FAIL stall_end_dv: got %b want 0", out_data_ready); end
    endtask

    task automatic test_back_to_back();
        int bases [6] = '{0, 4, 8, 1020, 12, 2};
        logic exp_r;
        logic exp_v;
        int j;
        int i;
        in_receive_enbl_mem = 1'b0;
        in_wrt_enbl_mem = 1'b0;
        for (int r = 0; r < 6; r++) begin
            in_mem_addr      = 32'(bases[r]);
            in_available_mem = 1'b1;
            exp_r = (r < 5);
            checks++; if (out_ready_to_receive !== exp_r) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", r, out_ready_to_receive, exp_r); end
            step();
        end
        in_available_mem = 1'b0;
        checks++; if (out_ready_to_receive !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b want 0", out_ready_to_receive); end
        in_receive_enbl_mem = 1'b1;
        for (int s = 0; s < 30; s++) begin
            if (s > 0) step();
            j = s / 6;
            i = s % 6;
            exp_v = (j < 5) && (i < 4);
            checks++; if (out_data_ready !== exp_v) begin errors++; $display("FAIL b2b_dv[%0d]: got %b want %b", s, out_data_ready, exp_v); end
            if (exp_v) begin
                checks++; if (out_mem_data !== model[(bases[j] + i) % 1024]) begin errors++; $display("FAIL b2b_beat[%0d.%0d]: got %h want %h", j, i, out_mem_data, model[(bases[j] + i) % 1024]); end
            end
        end
    endtask

    task automatic test_burst_count();
        checks++; if (out_wr_burst_count !== 16'd0) begin errors++; $display("FAIL cnt_start: got %0d want 0", out_wr_burst_count); end
        do_write(100, pat(100), 1'b1);
        checks++; if (out_wr_burst_count !== 16'd1) begin errors++; $display("FAIL cnt_one: got %0d want 1", out_wr_burst_count); end
        do_write(101, pat(101), 1'b1);
        checks++; if (out_wr_burst_count !== 16'd2) begin errors++; $display("FAIL cnt_two: got %0d want 2", out_wr_burst_count); end
        in_receive_enbl_mem = 1'b0;
        in_wrt_enbl_mem  = 1'b0;
        in_burst_done    = 1'b1;
        in_mem_addr      = 32'd0;
        in_available_mem = 1'b1;
        repeat (5) step();
        in_wrt_enbl_mem = 1'b1;
        in_mem_addr     = 32'd102;
        in_mem_data     = pat(102);
        checks++; if (out_ready_to_receive !== 1'b0) begin errors++; $display("FAIL cnt_full_ready: got %b want 0", out_ready_to_receive); end
        step();
        step();
        in_available_mem = 1'b0;
        in_burst_done    = 1'b0;
        checks++; if (out_wr_burst_count !== 16'd2) begin errors++; $display("FAIL cnt_blocked: got %0d want 2", out_wr_burst_count); end
        in_receive_enbl_mem = 1'b1;
        repeat (40) step();
        checks++; if (out_data_ready !== 1'b0 || out_ready_to_receive !== 1'b1) begin errors++; $display("FAIL cnt_drain: got dv=%b rdy=%b want dv=0 rdy=1", out_data_ready, out_ready_to_receive); end
        in_wrt_enbl_mem  = 1'b1;
        in_burst_done    = 1'b1;
        in_mem_addr      = 32'd200;
        in_mem_data      = pat(200);
        in_available_mem = 1'b1;
        repeat (65533) step();
        in_available_mem = 1'b0;
        in_burst_done    = 1'b0;
        model[200] = pat(200);
        checks++; if (out_wr_burst_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_max: got %h want ffff", out_wr_burst_count); end
        do_write(201, pat(201), 1'b1);
        checks++; if (out_wr_burst_count !== 16'h0000) begin errors++; $display("FAIL cnt_wrap: got %h want 0000", out_wr_burst_count); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_write(202, pat(202), 1'b1);
        in_receive_enbl_mem = 1'b0;
        do_read(4);
        do_read(8);
        do_read(0);
        wait_dv(20, cyc);
        checks++; if (cyc < 0) begin errors++; $display("FAIL rstmid_timeout: got no data_ready want data_ready within 20 cycles"); end
        rst = 1'b0;
        #1;
        checks++; if (out_data_ready !== 1'b0 || out_mem_data !== 512'd0) begin errors++; $display("FAIL rstmid_clear: got dv=%b %h want dv=0 0", out_data_ready, out_mem_data); end
        checks++; if (out_ready_to_receive !== 1'b0 || out_wr_burst_count !== 16'd0) begin errors++; $display("FAIL rstmid_ctrl: got rdy=%b cnt=%0d want rdy=0 cnt=0", out_ready_to_receive, out_wr_burst_count); end
        step();
        step();
        rst = 1'b1;
        in_receive_enbl_mem = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            checks++; if (out_data_ready !== 1'b0) begin errors++; $display("FAIL rstmid_quiet[%0d]: got %b want 0", k, out_data_ready); end
        end
        do_read(4);
        wait_dv(20, cyc);
        checks++; if (cyc < 0) begin errors++; $display("FAIL rstmid_fresh_timeout: got no data_ready want data_ready within 20 cycles"); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            checks++; if (out_mem_data !== model[4 + i]) begin errors++; $display("FAIL rstmid_beat[%0d]: got %h want %h", i, out_mem_data, model[4 + i]); end
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_basic_read();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_burst_count();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
